lbs_axis_frame_tx: RTL and testbench

Parametrised local-bus-loaded frame transmitter. A host writes a sample frame into an internal buffer over the lbs bus, then commands single-shot or continuous-repeat playback. The frame streams out on an AXI4-Stream master with tlast on the final beat. It generalises the fixed 2304-sample load/start mechanism used by the conversion datapath: width, depth, addresses and length are parameters, and repeat mode, abort and status readback are added.

---
 rtl/lbs_axis_frame_tx.sv | 192 +++++++++++++++++++
 tb/tb_lbs_axis_frame_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbs_axis_frame_tx.sv
`default_nettype none
// lbs_axis_frame_tx: bus-loaded frame buffer streamed out on an AXI4-Stream master,
// single-shot or repeating, with abort and status readback. Rev 1.0.
module lbs_axis_frame_tx #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2304,
  parameter int BUF_BASE  = 12000,
  parameter int CTRL_ADDR = 16000,
  parameter int LEN_ADDR  = 16001,
  parameter int STAT_ADDR = 16002
) (
  input  logic              lbs_clk,
  input  logic              rst_n,
  input  logic [15:0]       lbs_addr,
  input  logic [31:0]       lbs_din,
  input  logic              lbs_we,
  input  logic              lbs_re,
  output logic [31:0]       lbs_dout,
  output logic              axis_tx_tvalid,
  output logic [DATA_W-1:0] axis_tx_tdata,
  output logic              axis_tx_tlast,
  input  logic              axis_tx_tready,
  output logic              busy,
  output logic              frame_done
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] CTRL_A  = 16'(CTRL_ADDR);
  localparam logic [15:0] LEN_A   = 16'(LEN_ADDR);
  localparam logic [15:0] STAT_A  = 16'(STAT_ADDR);
  localparam logic [15:0] BUF_LO  = 16'(BUF_BASE);
  localparam logic [15:0] BUF_HI  = 16'(BUF_BASE + DEPTH - 1);
  localparam logic [15:0] DEPTH_L = 16'(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state;
  logic [AW-1:0]     rd_ptr;
  logic [15:0]       len;
  logic [15:0]       frame_cnt;
  logic              rpt, done, aborted, abort_drain;
  logic              skid_valid, skid_last, rd_valid, rd_last;
  logic [DATA_W-1:0] skid_data, mem_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          ctrl_wr, cmd_start, cmd_abort, cmd_load, len_wr, buf_wr;
  logic          pop, fetch, fetch_last;
  logic [15:0]   cmd;
  logic [1:0]    occ;
  logic [AW-1:0] buf_idx;

  assign cmd        = lbs_din[15:0];
  assign ctrl_wr    = lbs_we && (lbs_addr == CTRL_A);
  assign cmd_start  = ctrl_wr && ((cmd == 16'h8888) || (cmd == 16'hFFFF));
  assign cmd_abort  = ctrl_wr && (cmd == 16'h0000);
  assign cmd_load   = ctrl_wr && (cmd == 16'h5555);
  assign len_wr     = lbs_we && (lbs_addr == LEN_A) && (state != RUN);
  assign buf_wr     = lbs_we && (lbs_addr >= BUF_LO) && (lbs_addr <= BUF_HI) && (state == IDLE);
  assign buf_idx    = AW'(lbs_addr - BUF_LO);
  assign pop        = axis_tx_tvalid && axis_tx_tready;
  // Beats held or in flight; a fetch is only issued if it is guaranteed a slot.
  assign occ        = 2'(axis_tx_tvalid) + 2'(skid_valid) + 2'(rd_valid);
  assign fetch      = (state == RUN) && !cmd_abort && ((occ - 2'(pop)) <= 2'd1);
  assign fetch_last = (16'(rd_ptr) == (len - 16'd1));

  always_ff @(posedge lbs_clk) begin
    if (buf_wr)
      mem[buf_idx] <= lbs_din[DATA_W-1:0];
    if (fetch)
      mem_q <= mem[rd_ptr];
  end

  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      len            <= DEPTH_L;
      frame_cnt      <= '0;
      rpt            <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      abort_drain    <= 1'b0;
      skid_valid     <= 1'b0;
      skid_last      <= 1'b0;
      skid_data      <= '0;
      rd_valid       <= 1'b0;
      rd_last        <= 1'b0;
      axis_tx_tvalid <= 1'b0;
      axis_tx_tdata  <= '0;
      axis_tx_tlast  <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      lbs_dout       <= '0;
    end else begin
      busy       <= (state != IDLE);
      frame_done <= pop && axis_tx_tlast;
      rd_valid   <= fetch;
      rd_last    <= fetch_last;
      if (pop && axis_tx_tlast)
        frame_cnt <= frame_cnt + 16'd1;

      if (len_wr)
        len <= ((lbs_din == 32'd0) || (lbs_din > DEPTH_W)) ? DEPTH_L : lbs_din[15:0];

      if (lbs_re) begin
        if (lbs_addr == LEN_A)
          lbs_dout <= {16'd0, len};
        else if (lbs_addr == STAT_A)
          lbs_dout <= {frame_cnt, 12'd0, aborted, done, rpt, busy};
        else
          lbs_dout <= 32'd0;
      end

      // Output register refills from the skid slot first, then from the buffer read.
      if (!axis_tx_tvalid || pop) begin
        if (skid_valid) begin
          axis_tx_tvalid <= 1'b1;
          axis_tx_tdata  <= skid_data;
          axis_tx_tlast  <= skid_last;
          skid_valid     <= rd_valid;
          skid_data      <= mem_q;
          skid_last      <= rd_last;
        end else if (rd_valid) begin
          axis_tx_tvalid <= 1'b1;
          axis_tx_tdata  <= mem_q;
          axis_tx_tlast  <= rd_last;
        end else begin
          axis_tx_tvalid <= 1'b0;
        end
      end else if (rd_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= mem_q;
        skid_last  <= rd_last;
      end

      case (state)
        IDLE: begin
          if (cmd_start) begin
            state       <= RUN;
            rd_ptr      <= '0;
            rpt         <= (cmd == 16'hFFFF);
            frame_cnt   <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            abort_drain <= 1'b0;
          end else if (cmd_load) begin
            done    <= 1'b0;
            aborted <= 1'b0;
          end
        end
        RUN: begin
          if (fetch) begin
            if (fetch_last) begin
              rd_ptr <= '0;
              if (!rpt)
                state <= DRAIN;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && (abort_drain || axis_tx_tlast)) begin
            state <= IDLE;
            if (!abort_drain)
              done <= 1'b1;
          end
          if (cmd_load) begin
            done    <= 1'b0;
            aborted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort keeps only the beat already presented; prefetched beats are discarded.
      if (cmd_abort && (state != IDLE)) begin
        skid_valid  <= 1'b0;
        rd_valid    <= 1'b0;
        aborted     <= 1'b1;
        abort_drain <= 1'b1;
        if (pop || !axis_tx_tvalid) begin
          axis_tx_tvalid <= 1'b0;
          state          <= IDLE;
        end else begin
          state <= DRAIN;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lbs_axis_frame_tx.sv
`default_nettype none
// tb_lbs_axis_frame_tx: randomized bench with a stream-level reference model
// (frame beat i carries buffer word i mod len, tlast on i mod len == len-1).
module tb_lbs_axis_frame_tx;
  localparam int DEPTH = 16;
  localparam logic [15:0] CTRL_A = 16'd16000;
  localparam logic [15:0] LEN_A  = 16'd16001;
  localparam logic [15:0] STAT_A = 16'd16002;
  localparam int BUF_BASE = 12000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lbs_addr;
  logic [31:0] lbs_din;
  logic        lbs_we, lbs_re;
  logic [31:0] lbs_dout;
  logic        axis_tx_tvalid, axis_tx_tlast, busy, frame_done;
  logic [31:0] axis_tx_tdata;
  logic        axis_tx_tready = 1'b0;

  lbs_axis_frame_tx #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .lbs_clk(clk), .rst_n(rst_n), .lbs_addr(lbs_addr), .lbs_din(lbs_din),
    .lbs_we(lbs_we), .lbs_re(lbs_re), .lbs_dout(lbs_dout),
    .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tlast(axis_tx_tlast), .axis_tx_tready(axis_tx_tready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 3;
  logic [31:0] mdl_buf [DEPTH];
  int mdl_len = DEPTH;
  int mon_idx = 0, hs_cnt = 0, fd_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic prev_stall = 1'b0, prev_lh = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: axis_tx_tready = 1'b1;
      1: axis_tx_tready = ~axis_tx_tready;
      2: axis_tx_tready = 1'($urandom_range(0, 1));
      default: axis_tx_tready = 1'b0;
    endcase
  end

  // Stream monitor: beat content, stall stability and frame_done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_lh    = 1'b0;
    end else begin
      check("frame_done", {31'd0, frame_done}, {31'd0, prev_lh});
      if (frame_done) fd_cnt++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, axis_tx_tvalid}, 32'd1);
        check("hold_data", axis_tx_tdata, prev_data);
        check("hold_last", {31'd0, axis_tx_tlast}, {31'd0, prev_last});
      end
      if (axis_tx_tvalid && axis_tx_tready) begin
        check("beat_data", axis_tx_tdata, mdl_buf[mon_idx % mdl_len]);
        check("beat_last", {31'd0, axis_tx_tlast}, {31'd0, 1'((mon_idx % mdl_len) == mdl_len - 1)});
        if (hs_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs_cnt++;
        mon_idx++;
      end
      prev_lh    = axis_tx_tvalid && axis_tx_tready && axis_tx_tlast;
      prev_stall = axis_tx_tvalid && !axis_tx_tready;
      prev_data  = axis_tx_tdata;
      prev_last  = axis_tx_tlast;
    end
  end

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    lbs_addr = a; lbs_din = d; lbs_we = 1'b1;
    @(posedge clk); #1;
    lbs_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    lbs_addr = a; lbs_re = 1'b1;
    @(posedge clk); #1;
    lbs_re = 1'b0;
    d = lbs_dout;
  endtask

  task automatic set_len(input logic [31:0] v);
    bus_wr(LEN_A, v);
    mdl_len = ((v == 0) || (v > DEPTH)) ? DEPTH : int'(v);
  endtask

  task automatic wbuf(input int idx, input logic [31:0] v);
    bus_wr(16'(BUF_BASE + idx), v);
    mdl_buf[idx] = v;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) wbuf(i, $urandom);
  endtask

  task automatic start(input logic [15:0] c);
    hs_cnt = 0; fd_cnt = 0; mon_idx = 0;
    bus_wr(CTRL_A, {16'd0, c});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while ((busy || axis_tx_tvalid) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check(tag, {31'd0, 1'(n < 2000)}, 32'd1);
  endtask

  task automatic wait_hs(input int k, input logic need_last, input string tag);
    int n = 0;
    while (!(hs_cnt >= k && (!need_last || (axis_tx_tvalid && axis_tx_tlast))) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check(tag, {31'd0, 1'(n < 1000)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lbs_addr = '0; lbs_din = '0; lbs_we = 1'b0; lbs_re = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_buf[i] = '0;
    #3;
    check("rst_tvalid", {31'd0, axis_tx_tvalid}, 32'd0);
    check("rst_tdata", axis_tx_tdata, 32'd0);
    check("rst_tlast", {31'd0, axis_tx_tlast}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fdone", {31'd0, frame_done}, 32'd0);
    check("rst_dout", lbs_dout, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bus_rd(LEN_A, rd);  check("rst_len", rd, DEPTH);
    bus_rd(STAT_A, rd); check("rst_stat", rd, 32'd0);
    bus_rd(CTRL_A, rd); check("ctrl_rd", rd, 32'd0);

    // Single shot at full rate, with start latency.
    set_len(4);
    for (int i = 0; i < 4; i++) wbuf(i, 32'hA + i);
    bus_rd(16'(BUF_BASE), rd); check("buf_rd", rd, 32'd0);
    rdy_mode = 0;
    start(16'h8888);
    @(posedge clk); #1;
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_tvalid0", {31'd0, axis_tx_tvalid}, 32'd0);
    @(posedge clk); #1;
    check("lat_tvalid1", {31'd0, axis_tx_tvalid}, 32'd1);
    wait_idle("once_idle");
    check("once_hs", hs_cnt, 4);
    check("once_span", last_cyc - first_cyc, 3);
    check("once_fd", fd_cnt, 1);
    bus_rd(STAT_A, rd); check("once_stat", rd, 32'h0001_0004);

    // Same frame with a toggling ready.
    rdy_mode = 1;
    start(16'h8888);
    wait_idle("tog_idle");
    check("tog_hs", hs_cnt, 4);
    check("tog_fd", fd_cnt, 1);
    bus_rd(STAT_A, rd); check("tog_stat", rd, 32'h0001_0004);

    // Repeat mode, 9 beats, then abort with a beat stalled.
    rdy_mode = 0;
    set_len(3);
    fill_rand(3);
    start(16'hFFFF);
    wait_hs(9, 1'b0, "rep_wait");
    rdy_mode = 3;
    check("rep_span", last_cyc - first_cyc, 8);
    repeat (3) @(posedge clk);
    #1 bus_wr(CTRL_A, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rep_held", {31'd0, axis_tx_tvalid}, 32'd1);
    check("rep_busy", {31'd0, busy}, 32'd1);
    rdy_mode = 0;
    wait_idle("rep_idle");
    check("rep_hs", hs_cnt, 10);
    bus_rd(STAT_A, rd); check("rep_stat", rd, 32'h0003_000A);

    // LEN clamping, writes ignored during RUN.
    set_len(0);
    bus_rd(LEN_A, rd); check("len0", rd, DEPTH);
    set_len(DEPTH + 5);
    bus_rd(LEN_A, rd); check("len_big", rd, DEPTH);
    set_len(4);
    fill_rand(4);
    rdy_mode = 3;
    start(16'h8888);
    repeat (4) @(posedge clk);
    #1 bus_wr(16'(BUF_BASE + 1), ~mdl_buf[1]);
    bus_wr(LEN_A, 32'd2);
    bus_rd(LEN_A, rd); check("len_run", rd, 32'd4);
    rdy_mode = 0;
    wait_idle("run_wr_idle");
    check("run_wr_hs", hs_cnt, 4);
    start(16'h8888);
    wait_idle("old_word_idle");
    check("old_word_hs", hs_cnt, 4);

    // Abort with ready low mid-frame.
    rdy_mode = 3;
    start(16'h8888);
    repeat (5) @(posedge clk);
    #1 bus_wr(CTRL_A, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("ab_held", {31'd0, axis_tx_tvalid}, 32'd1);
    check("ab_tlast", {31'd0, axis_tx_tlast}, 32'd0);
    rdy_mode = 0;
    wait_idle("ab_idle");
    check("ab_hs", hs_cnt, 1);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_tvalid", {31'd0, axis_tx_tvalid}, 32'd0);
    bus_rd(STAT_A, rd); check("ab_stat", rd, 32'h0000_0008);
    bus_wr(CTRL_A, 32'h5555);
    bus_rd(STAT_A, rd); check("load_stat", rd, 32'h0000_0000);

    // Abort coinciding with a tlast handshake in repeat mode.
    set_len(2);
    fill_rand(2);
    rdy_mode = 0;
    start(16'hFFFF);
    wait_hs(4, 1'b1, "atl_wait");
    bus_wr(CTRL_A, 32'h0);
    check("atl_tvalid", {31'd0, axis_tx_tvalid}, 32'd0);
    wait_idle("atl_idle");
    check("atl_whole", hs_cnt % 2, 0);
    bus_rd(STAT_A, rd); check("atl_stat", rd, {16'(hs_cnt / 2), 16'h000A});

    // Random lengths and random backpressure.
    for (int t = 0; t < 4; t++) begin
      set_len($urandom_range(2, DEPTH));
      fill_rand(mdl_len);
      rdy_mode = 2;
      start(16'h8888);
      wait_idle("rnd_idle");
      check("rnd_hs", hs_cnt, mdl_len);
      check("rnd_fd", fd_cnt, 1);
      bus_rd(STAT_A, rd); check("rnd_stat", rd, 32'h0001_0004);
    end

    // Asynchronous reset mid-frame.
    set_len(4);
    fill_rand(4);
    rdy_mode = 1;
    start(16'h8888);
    wait_hs(2, 1'b0, "rst_wait");
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", {31'd0, axis_tx_tvalid}, 32'd0);
    check("arst_tlast", {31'd0, axis_tx_tlast}, 32'd0);
    check("arst_tdata", axis_tx_tdata, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_dout", lbs_dout, 32'd0);
    rdy_mode = 3;
    mdl_len = DEPTH;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_rd(LEN_A, rd);  check("arst_len", rd, DEPTH);
    bus_rd(STAT_A, rd); check("arst_stat", rd, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
